// File: rtl/grid_stream_reader_pkg.sv
// Shared constants and beat tag layout for the grid stream reader.
// A 50x50 grid (2500 words) needs a 13-bit byte address; the 12-bit
// default suits grids of up to 2048 words.
package grid_stream_reader_pkg;

  localparam int DATA_WIDTH_DEF    = 16;
  localparam int ADDRESS_WIDTH_DEF = 12;
  localparam int DEPTH             = 2048;
  localparam int GRID_W_DEF        = 50;
  localparam int GRID_H_DEF        = 50;
  localparam int ROW_COL_WIDTH     = 6;

  typedef logic [ROW_COL_WIDTH-1:0] rc_t;

  // Per-beat sideband carried through the output FIFO alongside the data word
  typedef struct packed {
    rc_t  row;
    rc_t  col;
    logic last;
`ifdef GRID_READER_HALO_EN
    logic halo;
`endif
  } beat_tag_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/grid_stream_reader_fifo.sv
// Purpose: 2-entry synchronous FIFO with push/pop/count, generic width.
// Latency: a pushed word is visible on pop_data the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module stream_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count_q != 2'd0);
  assign do_push  = push && ((count_q != 2'd2) || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign empty    = (count_q == 2'd0);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/grid_stream_reader.sv
// Purpose: sweeps a GRID_H x GRID_W region of the grid RAM row-major and streams it out tagged.
// Latency: first out_valid 2 cycles after start is accepted; 1 beat/cycle with out_ready high.
// Backpressure: reads throttle so issued-but-unpopped words never exceed the 2-entry FIFO.
// Optional GRID_READER_HALO_EN adds out_halo, flagging beats on the region border.
module grid_stream_reader
  import grid_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int GRID_W        = GRID_W_DEF,
  parameter int GRID_H        = GRID_H_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_index,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_write_en,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [ROW_COL_WIDTH-1:0] out_row,
  output logic [ROW_COL_WIDTH-1:0] out_col,
`ifdef GRID_READER_HALO_EN
  output logic                     out_halo,
`endif
  output logic                     out_last
);

  localparam int  TAG_W    = $bits(beat_tag_t);
  localparam int  FIFO_W   = DATA_WIDTH + TAG_W;
  localparam rc_t LAST_ROW = rc_t'(GRID_H - 1);
  localparam rc_t LAST_COL = rc_t'(GRID_W - 1);
  localparam rc_t RC_ONE   = rc_t'(1);
  localparam logic [ADDRESS_WIDTH-1:0] IDX_ONE = ADDRESS_WIDTH'(1);

  logic [1:0]               state_q;
  logic [ADDRESS_WIDTH-1:0] idx_q;
  rc_t                      row_q;
  rc_t                      col_q;
  logic                     inflight_q;
  beat_tag_t                tag_q;
  beat_tag_t                issue_tag;
  beat_tag_t                out_tag;
  logic [1:0]               fifo_count;
  logic                     fifo_empty;
  logic [FIFO_W-1:0]        fifo_out;
  logic [2:0]               occ;
  logic                     pop;
  logic                     issue;
  logic                     at_last;
  logic                     drain_done;
  logic [ADDRESS_WIDTH:0]   addr_wide;
  logic                     unused_addr_msb;

  // Occupancy counts words already in the FIFO plus the read whose data lands next cycle
  assign pop        = out_valid && out_ready;
  assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue      = (state_q == ST_ISSUE) && ((occ < 3'd2) || ((occ == 3'd2) && pop));
  assign at_last    = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign drain_done = !inflight_q && (fifo_empty || ((fifo_count == 2'd1) && pop));

  assign addr_wide       = {idx_q, 1'b0};
  assign mem_addr        = addr_wide[ADDRESS_WIDTH-1:0];
  assign unused_addr_msb = addr_wide[ADDRESS_WIDTH];
  assign mem_write_en    = 1'b0;

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_out[FIFO_W-1 -: DATA_WIDTH];
  assign out_tag   = fifo_out[TAG_W-1:0];
  assign out_row   = out_tag.row;
  assign out_col   = out_tag.col;
  assign out_last  = out_tag.last;
`ifdef GRID_READER_HALO_EN
  assign out_halo  = out_tag.halo;
`endif

  // Tags describing the read being issued this cycle
  always_comb begin
    issue_tag      = '0;
    issue_tag.row  = row_q;
    issue_tag.col  = col_q;
    issue_tag.last = at_last;
`ifdef GRID_READER_HALO_EN
    issue_tag.halo = (row_q == '0) || (row_q == LAST_ROW) || (col_q == '0) || (col_q == LAST_COL);
`endif
  end

  // Sweep FSM: running word index plus row/column counters, in-flight tag latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) tag_q <= issue_tag;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            idx_q   <= base_index;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            idx_q <= idx_q + IDX_ONE;
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + RC_ONE;
            end else begin
              col_q <= col_q + RC_ONE;
            end
            if (at_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_done) state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  stream_fifo2 #(.WIDTH(FIFO_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data ({mem_data_in, tag_q}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_grid_stream_reader.sv
// Bench for grid_stream_reader: a 50x50 instance on a 13-bit address bus and a
// 4x3 instance on the default 12-bit bus, each fed by a 1-cycle-latency RAM model.
module tb_grid_stream_reader;

  localparam int AW = 13;
  localparam int W  = 50;
  localparam int H  = 50;
  localparam int N  = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [12:0] base_index = '0;
  logic        busy, done, mem_write_en, out_valid, out_last;
  logic        out_ready = 1'b0;
  logic [12:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] out_data;
  logic [5:0]  out_row, out_col;

  logic        start_s = 1'b0;
  logic [11:0] base_s = '0;
  logic        busy_s, done_s, we_s, valid_s, last_s;
  logic        ready_s = 1'b1;
  logic [11:0] addr_s;
  logic [15:0] rdata_s = '0;
  logic [15:0] data_s;
  logic [5:0]  row_s, col_s;
`ifdef GRID_READER_HALO_EN
  logic        out_halo, halo_s;
`endif

  logic [15:0] ram   [4096];
  logic [15:0] ram_s [2048];

  int nchecks = 0;
  int nerr    = 0;

  logic [15:0] got_data[$];
  int          got_row[$];
  int          got_col[$];
  bit          got_last[$];
  bit          got_halo[$];
  int first_valid_cyc, done_cyc, done_cnt, we_bad, stall_bad, max_cnt, post_valid, post_busy;
  bit timed_out;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr[12:1]];
    rdata_s   <= ram_s[addr_s[11:1]];
  end

  grid_stream_reader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(AW), .GRID_W(W), .GRID_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .base_index(base_index), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_write_en(mem_write_en), .mem_data_in(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col),
`ifdef GRID_READER_HALO_EN
    .out_halo(out_halo),
`endif
    .out_last(out_last)
  );

  grid_stream_reader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(12), .GRID_W(4), .GRID_H(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .base_index(base_s), .busy(busy_s), .done(done_s),
    .mem_addr(addr_s), .mem_write_en(we_s), .mem_data_in(rdata_s),
    .out_valid(valid_s), .out_ready(ready_s), .out_data(data_s), .out_row(row_s),
    .out_col(col_s),
`ifdef GRID_READER_HALO_EN
    .out_halo(halo_s),
`endif
    .out_last(last_s)
  );

  // Runs one sweep on the big instance and records what the stream delivered.
  // rmode: 0 ready held high, 1 ready pattern 1-0-0-1, 2 random ready.
  task automatic drive_sweep(input int base, input int rmode, input int abort_at, input bit poke_start);
    int cyc = 0;
    int tail = -1;
    bit hold = 1'b0;
    logic [15:0] h_data;
    int h_row, h_col;
    logic h_last;
    got_data.delete(); got_row.delete(); got_col.delete(); got_last.delete(); got_halo.delete();
    first_valid_cyc = -1; done_cyc = -1; done_cnt = 0; we_bad = 0; stall_bad = 0; max_cnt = 0;
    post_valid = -1; post_busy = -1; timed_out = 1'b0;
    @(negedge clk);
    base_index = AW'(base);
    start = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = poke_start && (cyc == 100);
      if (poke_start && cyc == 100) base_index = AW'(base + 7);
      if (mem_write_en !== 1'b0) we_bad++;
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (tail < 0) tail = 3;
      end
      if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hold && (out_valid !== 1'b1 || out_data !== h_data || int'(out_row) != h_row ||
                   int'(out_col) != h_col || out_last !== h_last)) stall_bad++;
      hold = 1'b0;
      if (abort_at >= 0 && got_data.size() == abort_at && tail < 0) begin
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        post_valid = int'(out_valid);
        post_busy  = int'(busy);
        tail = 30;
      end else begin
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid === 1'b1) begin
          if (out_ready) begin
            got_data.push_back(out_data);
            got_row.push_back(int'(out_row));
            got_col.push_back(int'(out_col));
            got_last.push_back(out_last);
`ifdef GRID_READER_HALO_EN
            got_halo.push_back(out_halo);
`endif
          end else begin
            hold = 1'b1;
            h_data = out_data; h_row = int'(out_row); h_col = int'(out_col); h_last = out_last;
          end
        end
      end
      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
      if (cyc > 20000) begin
        timed_out = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    nchecks++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b want=0", busy); end
    nchecks++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b want=0", done); end
    nchecks++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    nchecks++; if (mem_addr !== 13'd0) begin nerr++; $display("FAIL reset_addr got=%0d want=0", mem_addr); end
    nchecks++; if (mem_write_en !== 1'b0) begin nerr++; $display("FAIL reset_we got=%b want=0", mem_write_en); end
    nchecks++; if (valid_s !== 1'b0 || busy_s !== 1'b0) begin nerr++; $display("FAIL reset_small got=%b%b want=00", valid_s, busy_s); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_sweep();
    int halo_n = 0;
    for (int i = 0; i < 4096; i++) ram[i] = 16'(i);
    drive_sweep(0, 0, -1, 1'b0);
    nchecks++; if (timed_out) begin nerr++; $display("FAIL full_timeout got=timeout want=done"); end
    nchecks++; if (got_data.size() != N) begin nerr++; $display("FAIL full_count got=%0d want=%0d", got_data.size(), N); end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      nchecks++;
      if (got_data[i] !== 16'(i) || got_row[i] != i / W || got_col[i] != i % W || got_last[i] != (i == N - 1)) begin
        nerr++;
        $display("FAIL full_beat%0d got=%0d r%0d c%0d l%0d want=%0d r%0d c%0d l%0d", i, got_data[i],
                 got_row[i], got_col[i], got_last[i], i, i / W, i % W, (i == N - 1));
      end
    end
    nchecks++; if (done_cnt != 1) begin nerr++; $display("FAIL full_done_pulses got=%0d want=1", done_cnt); end
    nchecks++; if (done_cyc - 1 < N + 1 || done_cyc - 1 > N + 3) begin nerr++; $display("FAIL full_cycles got=%0d want=%0d+-1", done_cyc - 1, N + 2); end
    nchecks++; if (first_valid_cyc - 1 != 2) begin nerr++; $display("FAIL first_valid_latency got=%0d want=2", first_valid_cyc - 1); end
    nchecks++; if (we_bad != 0) begin nerr++; $display("FAIL full_write_en got=%0d want=0", we_bad); end
`ifdef GRID_READER_HALO_EN
    foreach (got_halo[i]) if (got_halo[i]) halo_n++;
    nchecks++; if (halo_n != 2 * W + 2 * (H - 2)) begin nerr++; $display("FAIL halo_count got=%0d want=%0d", halo_n, 2 * W + 2 * (H - 2)); end
    if (got_halo.size() == N) begin
      for (int i = 0; i < N; i++) begin
        nchecks++;
        if (got_halo[i] != ((i / W == 0) || (i / W == H - 1) || (i % W == 0) || (i % W == W - 1))) begin
          nerr++; $display("FAIL halo_beat%0d got=%0d", i, got_halo[i]);
        end
      end
    end
`endif
  endtask

  task automatic test_backpressure();
    for (int m = 1; m <= 2; m++) begin
      int base = $urandom_range(0, 1500);
      for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
      drive_sweep(base, m, -1, 1'b0);
      nchecks++; if (timed_out || got_data.size() != N) begin nerr++; $display("FAIL bp%0d_count got=%0d want=%0d", m, got_data.size(), N); end
      for (int i = 0; i < got_data.size() && i < N; i++) begin
        nchecks++;
        if (got_data[i] !== ram[base + i] || got_row[i] != i / W || got_col[i] != i % W || got_last[i] != (i == N - 1)) begin
          nerr++; $display("FAIL bp%0d_beat%0d got=%h want=%h", m, i, got_data[i], ram[base + i]);
        end
      end
      nchecks++; if (stall_bad != 0) begin nerr++; $display("FAIL bp%0d_stable got=%0d want=0", m, stall_bad); end
      nchecks++; if (max_cnt > 2) begin nerr++; $display("FAIL bp%0d_fifo_count got=%0d want<=2", m, max_cnt); end
      nchecks++; if (done_cnt != 1) begin nerr++; $display("FAIL bp%0d_done got=%0d want=1", m, done_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    int base = $urandom_range(0, 1500);
    for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
    drive_sweep(base, 2, 37, 1'b0);
    nchecks++; if (got_data.size() != 37) begin nerr++; $display("FAIL abort_beats got=%0d want=37", got_data.size()); end
    nchecks++; if (post_valid != 0) begin nerr++; $display("FAIL abort_valid got=%0d want=0", post_valid); end
    nchecks++; if (post_busy != 0) begin nerr++; $display("FAIL abort_busy got=%0d want=0", post_busy); end
    nchecks++; if (done_cnt != 0) begin nerr++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
    drive_sweep(base, 2, -1, 1'b0);
    nchecks++; if (timed_out || got_data.size() != N) begin nerr++; $display("FAIL resweep_count got=%0d want=%0d", got_data.size(), N); end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      nchecks++;
      if (got_data[i] !== ram[base + i] || got_row[i] != i / W || got_col[i] != i % W) begin
        nerr++; $display("FAIL resweep_beat%0d got=%h want=%h", i, got_data[i], ram[base + i]);
      end
    end
  endtask

  task automatic test_start_busy();
    int base = $urandom_range(0, 1500);
    for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
    drive_sweep(base, 0, -1, 1'b1);
    nchecks++; if (timed_out || got_data.size() != N) begin nerr++; $display("FAIL restart_count got=%0d want=%0d", got_data.size(), N); end
    for (int i = 0; i < got_data.size() && i < N; i++) begin
      nchecks++;
      if (got_data[i] !== ram[base + i]) begin
        nerr++; $display("FAIL restart_beat%0d got=%h want=%h", i, got_data[i], ram[base + i]);
      end
    end
    nchecks++; if (done_cnt != 1) begin nerr++; $display("FAIL restart_done got=%0d want=1", done_cnt); end
    nchecks++; if (we_bad != 0) begin nerr++; $display("FAIL restart_we got=%0d want=0", we_bad); end
  endtask

  task automatic test_offset();
    int addrs[$];
    logic [15:0] d[$];
    int r[$], c[$];
    bit l[$];
    bit seen_done = 1'b0;
    for (int i = 0; i < 2048; i++) ram_s[i] = 16'($urandom);
    @(negedge clk);
    base_s = 12'd100;
    start_s = 1'b1;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      @(negedge clk);
      start_s = 1'b0;
      if (busy_s && (addrs.size() == 0 || addrs[$] != int'(addr_s))) addrs.push_back(int'(addr_s));
      if (valid_s === 1'b1) begin
        d.push_back(data_s); r.push_back(int'(row_s)); c.push_back(int'(col_s)); l.push_back(last_s);
      end
      if (done_s === 1'b1) seen_done = 1'b1;
    end
    nchecks++; if (!seen_done) begin nerr++; $display("FAIL offset_timeout got=no_done want=done"); end
    nchecks++; if (addrs.size() < 12) begin nerr++; $display("FAIL offset_addr_count got=%0d want>=12", addrs.size()); end
    for (int k = 0; k < 12 && k < addrs.size(); k++) begin
      nchecks++;
      if (addrs[k] != 200 + 2 * k) begin nerr++; $display("FAIL offset_addr%0d got=%0d want=%0d", k, addrs[k], 200 + 2 * k); end
    end
    nchecks++; if (d.size() != 12) begin nerr++; $display("FAIL offset_beats got=%0d want=12", d.size()); end
    for (int i = 0; i < d.size() && i < 12; i++) begin
      nchecks++;
      if (d[i] !== ram_s[100 + i] || r[i] != i / 4 || c[i] != i % 4 || l[i] != (i == 11)) begin
        nerr++; $display("FAIL offset_beat%0d got=%h r%0d c%0d l%0d want=%h r%0d c%0d l%0d", i, d[i], r[i], c[i], l[i],
                         ram_s[100 + i], i / 4, i % 4, (i == 11));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_offset();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
